pif_rom_arbiter: RTL and testbench

Shares the single-port 512-byte PIF boot ROM (1-cycle registered read, `oe` → `valid` echo) between the PIF 6502 core's byte fetches and a host-side burst reader used for boot-code readback toward the SI/debug path. The 6502 has priority, but a starvation counter forces host slots so bursts always complete. Sits directly between both requesters and the ROM instance.

---
 rtl/pif_rom_pkg.sv | 19 +
 rtl/pif_rom_burst_gen.sv | 89 ++++++++
 rtl/pif_rom_arbiter.sv | 105 ++++++++++
 tb/tb_pif_rom_arbiter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pif_rom_pkg.sv
// Shared constants and enumerations for the PIF boot ROM arbiter.
package pif_rom_pkg;

    localparam int PIF_ADDR_W = 9;
    localparam int PIF_DATA_W = 8;
    localparam int BURST_MAX  = 64;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_HOST = 2'd2
    } owner_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_e;

endpackage

// File: rtl/pif_rom_burst_gen.sv
// Host burst sequencer: address counter with wrap, remaining-issue and
// outstanding-return counts, and the completion pulse.
module pif_rom_burst_gen
    import pif_rom_pkg::*;
#(
    parameter int ADDR_W = PIF_ADDR_W,
    parameter int LEN_W  = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [LEN_W-1:0]  start_len,
    input  logic              issue,
    input  logic              ret,
    output logic              eligible,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] baddr
);

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  baddr_q, baddr_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic [LEN_W-1:0]   outst_q, outst_d;
    logic               bad_q, bad_d;
    logic               len_ok;
    logic               done_burst;

    assign len_ok   = (start_len != '0) && (start_len <= LEN_W'(BURST_MAX));
    assign eligible = (state_q == ST_BURST) && (rem_q != '0);
    assign busy     = (state_q == ST_BURST);
    assign baddr    = baddr_q;
    assign done     = bad_q | done_burst;

    // Burst state, counters and the delayed pulse for rejected lengths.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            baddr_q <= '0;
            rem_q   <= '0;
            outst_q <= '0;
            bad_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baddr_q <= baddr_d;
            rem_q   <= rem_d;
            outst_q <= outst_d;
            bad_q   <= bad_d;
        end
    end

    // Next-state: accept legal starts in IDLE, count issues/returns in BURST.
    always_comb begin
        state_d    = state_q;
        baddr_d    = baddr_q;
        rem_d      = rem_q;
        outst_d    = outst_q;
        bad_d      = 1'b0;
        done_burst = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (len_ok) begin
                        state_d = ST_BURST;
                        baddr_d = start_addr;
                        rem_d   = start_len;
                        outst_d = '0;
                    end else begin
                        bad_d = 1'b1;
                    end
                end
            end
            ST_BURST: begin
                if (issue) begin
                    baddr_d = baddr_q + ADDR_W'(1);
                    rem_d   = rem_q - LEN_W'(1);
                end
                outst_d = outst_q + LEN_W'(issue) - LEN_W'(ret);
                if ((rem_q == '0) && (outst_q == LEN_W'(1)) && ret) begin
                    done_burst = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: rtl/pif_rom_arbiter.sv
// Arbitrates the single-port PIF boot ROM between 6502 fetches and host
// bursts, with a starvation guard and one-entry return-owner tag.
module pif_rom_arbiter
    import pif_rom_pkg::*;
#(
    parameter int ADDR_W     = PIF_ADDR_W,
    parameter int DATA_W     = PIF_DATA_W,
    parameter int LEN_W      = 7,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic              cpu_gnt,
    output logic              cpu_valid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              host_start,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [LEN_W-1:0]  host_len,
    output logic              host_busy,
    output logic              host_valid,
    output logic [DATA_W-1:0] host_data,
    output logic              host_done,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_oe,
    input  logic              rom_valid,
    input  logic [DATA_W-1:0] rom_q
);

    localparam int SW = $clog2(STARVE_MAX + 1);

    logic              host_elig;
    logic              host_gnt;
    logic              cpu_win;
    logic              gen_done;
    logic [ADDR_W-1:0] baddr;
    owner_e            tag_q, tag_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic [ADDR_W-1:0] last_addr_q;

    pif_rom_burst_gen #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_burst (
        .clk        (clk),
        .reset      (reset),
        .start      (host_start),
        .start_addr (host_addr),
        .start_len  (host_len),
        .issue      (host_gnt),
        .ret        (host_valid),
        .eligible   (host_elig),
        .busy       (host_busy),
        .done       (gen_done),
        .baddr      (baddr)
    );

    assign cpu_gnt   = cpu_win;
    assign host_done = !reset && gen_done;

    // Per-cycle winner selection, ROM drive, owner tag and starvation count.
    always_comb begin
        host_gnt = !reset && host_elig && (!cpu_req || (starve_q == SW'(STARVE_MAX)));
        cpu_win  = !reset && cpu_req && !host_gnt;
        rom_oe   = host_gnt || cpu_win;
        rom_addr = last_addr_q;
        tag_d    = OWN_NONE;
        starve_d = '0;
        if (reset) begin
            rom_addr = '0;
        end else if (host_gnt) begin
            rom_addr = baddr;
            tag_d    = OWN_HOST;
        end else if (cpu_win) begin
            rom_addr = cpu_addr;
            tag_d    = OWN_CPU;
        end
        if (host_elig && cpu_win) begin
            starve_d = (starve_q == SW'(STARVE_MAX)) ? starve_q : starve_q + SW'(1);
        end
    end

    // Route each ROM return to the requester that issued it; reset drops it.
    always_comb begin
        cpu_valid  = !reset && rom_valid && (tag_q == OWN_CPU);
        host_valid = !reset && rom_valid && (tag_q == OWN_HOST);
        cpu_rdata  = cpu_valid  ? rom_q : '0;
        host_data  = host_valid ? rom_q : '0;
    end

    // Owner tag, starvation counter and the held ROM address.
    always_ff @(posedge clk) begin
        if (reset) begin
            tag_q       <= OWN_NONE;
            starve_q    <= '0;
            last_addr_q <= '0;
        end else begin
            tag_q       <= tag_d;
            starve_q    <= starve_d;
            last_addr_q <= rom_addr;
        end
    end

endmodule

// File: tb/tb_pif_rom_arbiter.sv
// Directed self-checking bench for pif_rom_arbiter with a behavioural ROM.
module tb_pif_rom_arbiter;

    logic       clk;
    logic       reset;
    logic       cpu_req;
    logic [8:0] cpu_addr;
    logic       cpu_gnt;
    logic       cpu_valid;
    logic [7:0] cpu_rdata;
    logic       host_start;
    logic [8:0] host_addr;
    logic [6:0] host_len;
    logic       host_busy;
    logic       host_valid;
    logic [7:0] host_data;
    logic       host_done;
    logic [8:0] rom_addr;
    logic       rom_oe;
    logic       rom_valid;
    logic [7:0] rom_q;

    logic [7:0] mem [512];
    int vectors;
    int miscompares;

    pif_rom_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_addr   (cpu_addr),
        .cpu_gnt    (cpu_gnt),
        .cpu_valid  (cpu_valid),
        .cpu_rdata  (cpu_rdata),
        .host_start (host_start),
        .host_addr  (host_addr),
        .host_len   (host_len),
        .host_busy  (host_busy),
        .host_valid (host_valid),
        .host_data  (host_data),
        .host_done  (host_done),
        .rom_addr   (rom_addr),
        .rom_oe     (rom_oe),
        .rom_valid  (rom_valid),
        .rom_q      (rom_q)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM contents pattern, used both to fill the ROM and to predict data.
    function automatic logic [7:0] romExp(input logic [8:0] a);
        int v;
        v = int'(a) * 37 + (int'(a) >> 3) + 5;
        return 8'(v);
    endfunction

    // Single-port ROM with one-cycle registered read and oe echo.
    always @(posedge clk) begin
        rom_valid <= rom_oe;
        if (rom_oe) rom_q <= mem[rom_addr];
    end

    task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One cycle: drive inputs just after the edge, settle before sampling.
    task automatic applyStimulus(input logic req, input logic [8:0] ca,
                                 input logic hs, input logic [8:0] ha, input logic [6:0] hl);
        @(posedge clk);
        #1;
        cpu_req    = req;
        cpu_addr   = ca;
        host_start = hs;
        host_addr  = ha;
        host_len   = hl;
        #2;
    endtask

    task automatic runHostOnly(input string name, input logic [8:0] addr, input int len);
        logic [8:0] ea;
        applyStimulus(1'b0, 9'h0, 1'b1, addr, 7'(len));
        checkOutput({name, "_busy_start"}, 16'(host_busy), 16'd0);
        for (int k = 1; k <= len + 2; k++) begin
            applyStimulus(1'b0, 9'h0, 1'b0, 9'h0, 7'd0);
            checkOutput({name, "_oe"}, 16'(rom_oe), 16'(k <= len));
            if (k <= len) begin
                ea = addr + 9'(k - 1);
                checkOutput({name, "_rom_addr"}, 16'(rom_addr), 16'(ea));
            end
            checkOutput({name, "_valid"}, 16'(host_valid), 16'(k >= 2 && k <= len + 1));
            if (k >= 2 && k <= len + 1) begin
                ea = addr + 9'(k - 2);
                checkOutput({name, "_data"}, 16'(host_data), 16'(romExp(ea)));
            end
            checkOutput({name, "_done"}, 16'(host_done), 16'(k == len + 1));
            checkOutput({name, "_busy"}, 16'(host_busy), 16'(k <= len + 1));
        end
    endtask

    initial begin
        logic       prevCpu;
        logic [8:0] prevAddr;
        logic [8:0] ca;
        logic [8:0] hostNext;
        logic       expCpu;
        int         cnt;
        int         doneCnt;

        vectors     = 0;
        miscompares = 0;
        for (int i = 0; i < 512; i++) mem[i] = romExp(9'(i));
        reset      = 1'b1;
        cpu_req    = 1'b1;
        cpu_addr   = 9'h055;
        host_start = 1'b0;
        host_addr  = 9'h0;
        host_len   = 7'd0;

        // Reset: requests present but nothing may be granted.
        applyStimulus(1'b1, 9'h055, 1'b0, 9'h0, 7'd0);
        applyStimulus(1'b1, 9'h055, 1'b0, 9'h0, 7'd0);
        checkOutput("rst_rom_oe", 16'(rom_oe), 16'd0);
        checkOutput("rst_cpu_gnt", 16'(cpu_gnt), 16'd0);
        checkOutput("rst_rom_addr", 16'(rom_addr), 16'd0);
        checkOutput("rst_busy", 16'(host_busy), 16'd0);
        checkOutput("rst_cpu_valid", 16'(cpu_valid), 16'd0);
        checkOutput("rst_done", 16'(host_done), 16'd0);
        reset = 1'b0;
        applyStimulus(1'b0, 9'h0, 1'b0, 9'h0, 7'd0);
        applyStimulus(1'b0, 9'h0, 1'b0, 9'h0, 7'd0);

        // CPU only: three back-to-back fetches.
        applyStimulus(1'b1, 9'h000, 1'b0, 9'h0, 7'd0);
        checkOutput("cpu_gnt0", 16'(cpu_gnt), 16'd1);
        checkOutput("cpu_addr0", 16'(rom_addr), 16'h000);
        applyStimulus(1'b1, 9'h001, 1'b0, 9'h0, 7'd0);
        checkOutput("cpu_gnt1", 16'(cpu_gnt), 16'd1);
        checkOutput("cpu_valid0", 16'(cpu_valid), 16'd1);
        checkOutput("cpu_data0", 16'(cpu_rdata), 16'(romExp(9'h000)));
        applyStimulus(1'b1, 9'h1FF, 1'b0, 9'h0, 7'd0);
        checkOutput("cpu_gnt2", 16'(cpu_gnt), 16'd1);
        checkOutput("cpu_data1", 16'(cpu_rdata), 16'(romExp(9'h001)));
        checkOutput("cpu_host_valid", 16'(host_valid), 16'd0);
        applyStimulus(1'b0, 9'h000, 1'b0, 9'h0, 7'd0);
        checkOutput("cpu_idle_gnt", 16'(cpu_gnt), 16'd0);
        checkOutput("cpu_idle_oe", 16'(rom_oe), 16'd0);
        checkOutput("cpu_addr_hold", 16'(rom_addr), 16'h1FF);
        checkOutput("cpu_valid2", 16'(cpu_valid), 16'd1);
        checkOutput("cpu_data2", 16'(cpu_rdata), 16'(romExp(9'h1FF)));
        applyStimulus(1'b0, 9'h000, 1'b0, 9'h0, 7'd0);
        checkOutput("cpu_valid_off", 16'(cpu_valid), 16'd0);

        // Host-only bursts, plain and wrapping past the top of the ROM.
        runHostOnly("host", 9'h010, 4);
        runHostOnly("wrap", 9'h1FE, 4);

        // Starvation: CPU requests every cycle during a 3-byte burst.
        applyStimulus(1'b1, 9'h03F, 1'b1, 9'h100, 7'd3);
        checkOutput("starve_first_gnt", 16'(cpu_gnt), 16'd1);
        prevCpu  = 1'b1;
        prevAddr = 9'h03F;
        hostNext = 9'h100;
        cnt      = 0;
        for (int k = 0; k <= 15; k++) begin
            ca = 9'h040 + 9'(k);
            applyStimulus(1'b1, ca, 1'b0, 9'h0, 7'd0);
            expCpu = (k == 15) || ((k % 5) != 4);
            checkOutput("starve_cpu_gnt", 16'(cpu_gnt), 16'(expCpu));
            checkOutput("starve_rom_addr", 16'(rom_addr), expCpu ? 16'(ca) : 16'(hostNext));
            checkOutput("starve_cpu_valid", 16'(cpu_valid), 16'(prevCpu));
            checkOutput("starve_host_valid", 16'(host_valid), 16'(!prevCpu));
            if (prevCpu) checkOutput("starve_cpu_data", 16'(cpu_rdata), 16'(romExp(prevAddr)));
            else         checkOutput("starve_host_data", 16'(host_data), 16'(romExp(prevAddr)));
            checkOutput("starve_done", 16'(host_done), 16'(k == 15));
            prevCpu  = expCpu;
            prevAddr = expCpu ? ca : hostNext;
            if (!expCpu) begin
                hostNext = hostNext + 9'd1;
                cnt++;
            end
        end
        checkOutput("starve_host_grants", 16'(cnt), 16'd3);
        applyStimulus(1'b0, 9'h0, 1'b0, 9'h0, 7'd0);
        checkOutput("starve_busy_end", 16'(host_busy), 16'd0);
        checkOutput("starve_last_cpu", 16'(cpu_rdata), 16'(romExp(9'h04F)));

        // Zero and oversized lengths: done next cycle, no ROM access.
        applyStimulus(1'b0, 9'h0, 1'b1, 9'h050, 7'd0);
        checkOutput("len0_oe_start", 16'(rom_oe), 16'd0);
        applyStimulus(1'b0, 9'h0, 1'b0, 9'h0, 7'd0);
        checkOutput("len0_done", 16'(host_done), 16'd1);
        checkOutput("len0_busy", 16'(host_busy), 16'd0);
        checkOutput("len0_oe", 16'(rom_oe), 16'd0);
        applyStimulus(1'b0, 9'h0, 1'b1, 9'h050, 7'd65);
        checkOutput("len65_no_done_yet", 16'(host_done), 16'd0);
        applyStimulus(1'b0, 9'h0, 1'b0, 9'h0, 7'd0);
        checkOutput("len65_done", 16'(host_done), 16'd1);
        checkOutput("len65_busy", 16'(host_busy), 16'd0);
        checkOutput("len65_oe", 16'(rom_oe), 16'd0);
        applyStimulus(1'b0, 9'h0, 1'b0, 9'h0, 7'd0);
        checkOutput("len65_done_off", 16'(host_done), 16'd0);

        // A second start while busy must not change the running burst.
        applyStimulus(1'b0, 9'h0, 1'b1, 9'h020, 7'd3);
        cnt     = 0;
        doneCnt = 0;
        for (int k = 1; k <= 6; k++) begin
            if (k == 1) applyStimulus(1'b0, 9'h0, 1'b1, 9'h100, 7'd5);
            else        applyStimulus(1'b0, 9'h0, 1'b0, 9'h0, 7'd0);
            if (k == 2) checkOutput("ignore_rom_addr", 16'(rom_addr), 16'h021);
            if (host_valid) begin
                checkOutput("ignore_data", 16'(host_data), 16'(romExp(9'h020 + 9'(cnt))));
                cnt++;
            end
            if (host_done) doneCnt++;
        end
        checkOutput("ignore_count", 16'(cnt), 16'd3);
        checkOutput("ignore_done_cnt", 16'(doneCnt), 16'd1);
        checkOutput("ignore_busy_end", 16'(host_busy), 16'd0);

        // Reset after two returned bytes of an 8-byte burst.
        applyStimulus(1'b0, 9'h0, 1'b1, 9'h030, 7'd8);
        applyStimulus(1'b0, 9'h0, 1'b0, 9'h0, 7'd0);
        applyStimulus(1'b0, 9'h0, 1'b0, 9'h0, 7'd0);
        applyStimulus(1'b0, 9'h0, 1'b0, 9'h0, 7'd0);
        checkOutput("mid_second_byte", 16'(host_data), 16'(romExp(9'h031)));
        reset = 1'b1;
        applyStimulus(1'b0, 9'h0, 1'b0, 9'h0, 7'd0);
        checkOutput("mid_rst_valid", 16'(host_valid), 16'd0);
        checkOutput("mid_rst_oe", 16'(rom_oe), 16'd0);
        checkOutput("mid_rst_done", 16'(host_done), 16'd0);
        reset = 1'b0;
        applyStimulus(1'b0, 9'h0, 1'b0, 9'h0, 7'd0);
        checkOutput("post_rst_busy", 16'(host_busy), 16'd0);
        checkOutput("post_rst_valid", 16'(host_valid), 16'd0);
        checkOutput("post_rst_done", 16'(host_done), 16'd0);
        checkOutput("post_rst_oe", 16'(rom_oe), 16'd0);
        checkOutput("post_rst_addr", 16'(rom_addr), 16'd0);
        checkOutput("post_rst_cpu_valid", 16'(cpu_valid), 16'd0);
        checkOutput("post_rst_data", 16'(host_data), 16'd0);
        applyStimulus(1'b0, 9'h0, 1'b0, 9'h0, 7'd0);
        checkOutput("post_rst_done2", 16'(host_done), 16'd0);
        checkOutput("post_rst_oe2", 16'(rom_oe), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
